// File: rtl/cond_status_unit.sv
// cond_status_unit: committed condition flags with same-cycle writeback bypass,
// per-channel condition decode, and a pending-flag-writer interlock.
module cond_status_unit #(
    parameter int N_CH     = 2,
    parameter int PIPE     = 1,
    parameter int MAX_PEND = 3,
    localparam int PW      = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_s,
    input  logic              upd_en,
    input  logic [3:0]        upd_flags,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [4*N_CH-1:0] in_cond,
    output logic [N_CH-1:0]   out_valid,
    output logic [N_CH-1:0]   out_pass,
    output logic              stall,
    output logic [3:0]        status_q,
    output logic [PW-1:0]     pend_cnt,
    output logic              pend_err
);
    // Odd codes are the inverse of the even code below them, so decode pairs.
    function automatic logic f_decode(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, b;
        {z, cy, n, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cy;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cy & ~z;
            3'd5:    b = n == v;
            3'd6:    b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    logic [3:0]      r_status;
    logic [PW-1:0]   r_pend;
    logic [PW-1:0]   w_pend_next;
    logic            r_err;
    logic [3:0]      w_eff;
    logic [N_CH-1:0] w_dep, w_valid, w_pass;
    logic            w_inc, w_dec, w_ovf, w_unf;

    assign w_eff    = upd_en ? upd_flags : r_status;
    assign stall    = (|w_dep) && (r_pend > PW'(upd_en));
    assign status_q = r_status;
    assign pend_cnt = r_pend;
    assign pend_err = r_err;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_dep[k]   = in_valid[k] & (in_cond[4*k+1 +: 3] != 3'b111);
        assign w_valid[k] = in_valid[k] & ~stall & ~flush;
        assign w_pass[k]  = w_valid[k] & f_decode(in_cond[4*k +: 4], w_eff);
    end

    assign w_inc = issue_s & ~upd_en;
    assign w_dec = upd_en & ~issue_s;
    assign w_ovf = w_inc && (r_pend == PW'(MAX_PEND));
    assign w_unf = w_dec && (r_pend == '0);

    // Flush overrides the count only; an out-of-range request still flags an error.
    always_comb begin
        w_pend_next = flush ? '0 :
                      (w_ovf | w_unf) ? r_pend :
                      w_inc ? r_pend + 1'b1 :
                      w_dec ? r_pend - 1'b1 : r_pend;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= '0;
            r_pend   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (upd_en) r_status <= upd_flags;
            r_pend <= w_pend_next;
            r_err  <= r_err | w_ovf | w_unf;
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic [N_CH-1:0] r_valid, r_pass;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_valid <= '0;
                r_pass  <= '0;
            end else begin
                r_valid <= w_valid;
                r_pass  <= w_pass;
            end
        end
        assign out_valid = r_valid;
        assign out_pass  = r_pass;
    end else begin : g_comb
        assign out_valid = w_valid;
        assign out_pass  = w_pass;
    end
endmodule
